// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way, 4-set write-back cache controller.
//   INDEX_W/TAG_W/DATA_W : address split and line width
//   line_t               : one cache line {valid, dirty, tag, data}
//   state_e              : controller sequencing states
//   line_addr()          : backing-memory address of a line, {tag, index}
package cache_pkg;

  localparam int INDEX_W  = 2;
  localparam int TAG_W    = 3;
  localparam int DATA_W   = 3;
  localparam int NUM_WAYS = 2;
  localparam int NUM_SETS = 1 << INDEX_W;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_REFILL    = 3'd3,
    S_RESPOND   = 3'd4
  } state_e;

  function automatic logic [TAG_W+INDEX_W-1:0] line_addr(
    input logic [TAG_W-1:0]   tag,
    input logic [INDEX_W-1:0] index
  );
    return {tag, index};
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Line storage for the 2-way, 4-set cache plus one LRU bit per set.
//   rd_index/rd_tag   : combinational lookup; rd_hit[w] = valid & tag match
//   rd_line0/rd_line1 : contents of both ways of the addressed set
//   rd_lru            : way that is the replacement candidate for the set
//   wr_en/wr_way/wr_index/wr_line : synchronous line write; the written
//                       way becomes most-recently used (LRU points to the other)
//   rst               : asynchronously clears every line and LRU bit
module cache_tag_store
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic [1:0]         rd_hit,
  output line_t              rd_line0,
  output line_t              rd_line1,
  output logic               rd_lru,
  input  logic               wr_en,
  input  logic               wr_way,
  input  logic [INDEX_W-1:0] wr_index,
  input  line_t              wr_line
);

  line_t               lines_q [NUM_WAYS][NUM_SETS];
  line_t               lines_d [NUM_WAYS][NUM_SETS];
  logic [NUM_SETS-1:0] lru_q;
  logic [NUM_SETS-1:0] lru_d;

  always_comb begin
    rd_line0  = lines_q[0][rd_index];
    rd_line1  = lines_q[1][rd_index];
    rd_hit[0] = rd_line0.valid && (rd_line0.tag == rd_tag);
    rd_hit[1] = rd_line1.valid && (rd_line1.tag == rd_tag);
    rd_lru    = lru_q[rd_index];
  end

  always_comb begin
    lines_d = lines_q;
    lru_d   = lru_q;
    if (wr_en) begin
      lines_d[wr_way][wr_index] = wr_line;
      lru_d[wr_index]           = ~wr_way;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
        for (int unsigned s = 0; s < NUM_SETS; s++) begin
          lines_q[w][s] <= '0;
        end
      end
      lru_q <= '0;
    end else begin
      lines_q <= lines_d;
      lru_q   <= lru_d;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Sequencing controller for a 2-way, 4-set write-back cache.
//   req_*      : core request port (valid/ready handshake, one at a time)
//   resp_*     : one-cycle response pulse with hit flag and data
//   mem_*      : backing-memory port; write-back (mem_we=1) or refill,
//                held stable until the single-cycle mem_ack
//   *_count    : saturating hit / miss / write-back statistics
// All outputs come from registers or from the state register only.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wr,
  input  logic [INDEX_W-1:0]       req_index,
  input  logic [TAG_W-1:0]         req_tag,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [TAG_W+INDEX_W-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [CNT_W-1:0]         hit_count,
  output logic [CNT_W-1:0]         miss_count,
  output logic [CNT_W-1:0]         wb_count
);

  state_e              state_q,  state_d;
  logic                wr_q,     wr_d;
  logic [INDEX_W-1:0]  index_q,  index_d;
  logic [TAG_W-1:0]    tag_q,    tag_d;
  logic [DATA_W-1:0]   wdata_q,  wdata_d;
  logic                victim_q, victim_d;
  logic [TAG_W-1:0]    vtag_q,   vtag_d;
  logic [DATA_W-1:0]   vdata_q,  vdata_d;
  logic                hit_q,    hit_d;
  logic [DATA_W-1:0]   data_q,   data_d;
  logic [CNT_W-1:0]    hits_q,   hits_d;
  logic [CNT_W-1:0]    misses_q, misses_d;
  logic [CNT_W-1:0]    wbs_q,    wbs_d;

  logic [1:0] rd_hit;
  line_t      rd_line0;
  line_t      rd_line1;
  logic       rd_lru;
  logic       st_wr_en;
  logic       st_wr_way;
  line_t      st_wr_line;
  line_t      hit_line;
  line_t      victim_line;
  logic       victim_way;

  cache_tag_store u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_index (index_q),
    .rd_tag   (tag_q),
    .rd_hit   (rd_hit),
    .rd_line0 (rd_line0),
    .rd_line1 (rd_line1),
    .rd_lru   (rd_lru),
    .wr_en    (st_wr_en),
    .wr_way   (st_wr_way),
    .wr_index (index_q),
    .wr_line  (st_wr_line)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    hit_line = rd_hit[1] ? rd_line1 : rd_line0;
    if (!rd_line0.valid) begin
      victim_way = 1'b0;
    end else if (!rd_line1.valid) begin
      victim_way = 1'b1;
    end else begin
      victim_way = rd_lru;
    end
    victim_line = victim_way ? rd_line1 : rd_line0;
  end

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    index_d    = index_q;
    tag_d      = tag_q;
    wdata_d    = wdata_q;
    victim_d   = victim_q;
    vtag_d     = vtag_q;
    vdata_d    = vdata_q;
    hit_d      = hit_q;
    data_d     = data_q;
    hits_d     = hits_q;
    misses_d   = misses_q;
    wbs_d      = wbs_q;
    st_wr_en   = 1'b0;
    st_wr_way  = 1'b0;
    st_wr_line = '0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          index_d = req_index;
          tag_d   = req_tag;
          wdata_d = req_wdata;
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (|rd_hit) begin
          // Hits update the line and LRU here; RESPOND only writes misses.
          st_wr_en   = 1'b1;
          st_wr_way  = rd_hit[1];
          st_wr_line = hit_line;
          if (wr_q) begin
            st_wr_line.data  = wdata_q;
            st_wr_line.dirty = 1'b1;
          end
          hit_d   = 1'b1;
          data_d  = st_wr_line.data;
          hits_d  = sat_inc(hits_q);
          state_d = S_RESPOND;
        end else begin
          hit_d    = 1'b0;
          data_d   = wdata_q;
          misses_d = sat_inc(misses_q);
          victim_d = victim_way;
          vtag_d   = victim_line.tag;
          vdata_d  = victim_line.data;
          if (victim_line.valid && victim_line.dirty) begin
            state_d = S_WRITEBACK;
          end else if (wr_q) begin
            state_d = S_RESPOND;
          end else begin
            state_d = S_REFILL;
          end
        end
      end

      S_WRITEBACK: begin
        if (mem_ack) begin
          wbs_d   = sat_inc(wbs_q);
          state_d = wr_q ? S_RESPOND : S_REFILL;
        end
      end

      S_REFILL: begin
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = S_RESPOND;
        end
      end

      S_RESPOND: begin
        // data_q already holds the refill data (read) or wdata (write).
        st_wr_en         = !hit_q;
        st_wr_way        = victim_q;
        st_wr_line.valid = 1'b1;
        st_wr_line.dirty = wr_q;
        st_wr_line.tag   = tag_q;
        st_wr_line.data  = data_q;
        state_d          = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      index_q  <= '0;
      tag_q    <= '0;
      wdata_q  <= '0;
      victim_q <= 1'b0;
      vtag_q   <= '0;
      vdata_q  <= '0;
      hit_q    <= 1'b0;
      data_q   <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      index_q  <= index_d;
      tag_q    <= tag_d;
      wdata_q  <= wdata_d;
      victim_q <= victim_d;
      vtag_q   <= vtag_d;
      vdata_q  <= vdata_d;
      hit_q    <= hit_d;
      data_q   <= data_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      wbs_q    <= wbs_d;
    end
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESPOND);
    resp_hit   = resp_valid && hit_q;
    resp_data  = resp_valid ? data_q : '0;
    mem_req    = (state_q == S_WRITEBACK) || (state_q == S_REFILL);
    mem_we     = (state_q == S_WRITEBACK);
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state_q == S_WRITEBACK) begin
      mem_addr  = line_addr(vtag_q, index_q);
      mem_wdata = vdata_q;
    end else if (state_q == S_REFILL) begin
      mem_addr  = line_addr(tag_q, index_q);
    end
    hit_count  = hits_q;
    miss_count = misses_q;
    wb_count   = wbs_q;
  end

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic [1:0] req_index = '0;
  logic [2:0] req_tag = '0;
  logic [2:0] req_wdata = '0;
  logic       resp_valid;
  logic       resp_hit;
  logic [2:0] resp_data;
  logic       mem_req;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [2:0] mem_wdata;
  logic       mem_ack = 1'b0;
  logic [2:0] mem_rdata = '0;
  logic [7:0] hit_count;
  logic [7:0] miss_count;
  logic [7:0] wb_count;

  always #5 clk = ~clk;

  cache_ctrl #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_index  (req_index),
    .req_tag    (req_tag),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_data  (resp_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .wb_count   (wb_count)
  );

  typedef struct {
    bit         we;
    logic [4:0] addr;
    logic [2:0] wdata;
  } mtx_t;

  typedef struct {
    bit         hit;
    logic [2:0] data;
    bit         mem;
  } rsp_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cache contents, replacement bits, memory, statistics.
  bit         m_valid [2][4];
  bit         m_dirty [2][4];
  logic [2:0] m_tag   [2][4];
  logic [2:0] m_data  [2][4];
  int         m_lru   [4];
  logic [2:0] bmem    [32];
  logic [7:0] m_hits, m_misses, m_wbs;
  mtx_t       exp_mem  [$];
  rsp_t       exp_resp [$];

  // Observation state shared between monitor and directed sequences.
  bit         outstanding = 0;
  int         cyc = 0, hs_cyc = 0, ack_cyc = 0;
  int         resp_seen = 0;
  int         mem_cycles = 0;
  bit         last_hit;
  logic [2:0] last_data;
  int         last_lat;
  mtx_t       log_mem [$];
  int         delay_cfg = 0;   // negative: random 0..3 per transaction
  bit         spurious_en = 0;
  bit         busy = 0;
  int         wait_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout or unexpected event (t=%0t)", name, $time);
  endtask

  function automatic logic [7:0] sinc(input logic [7:0] v);
    return (v == 8'd255) ? v : v + 8'd1;
  endfunction

  function automatic void model_clear();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 4; s++) begin
        m_valid[w][s] = 0;
        m_dirty[w][s] = 0;
      end
    for (int s = 0; s < 4; s++) m_lru[s] = 0;
    m_hits = 0; m_misses = 0; m_wbs = 0;
    exp_mem.delete();
    exp_resp.delete();
  endfunction

  function automatic void predict(input bit wr, input logic [1:0] idx,
                                  input logic [2:0] tag, input logic [2:0] wd);
    int   hw = -1;
    int   v;
    rsp_t r;
    mtx_t t;
    for (int w = 0; w < 2; w++)
      if (m_valid[w][idx] && m_tag[w][idx] == tag) hw = w;
    if (hw >= 0) begin
      if (wr) begin
        m_data[hw][idx]  = wd;
        m_dirty[hw][idx] = 1;
      end
      m_lru[idx] = 1 - hw;
      m_hits = sinc(m_hits);
      r.hit = 1; r.data = m_data[hw][idx]; r.mem = 0;
    end else begin
      m_misses = sinc(m_misses);
      if (!m_valid[0][idx]) v = 0;
      else if (!m_valid[1][idx]) v = 1;
      else v = m_lru[idx];
      r.hit = 0; r.mem = 0;
      if (m_valid[v][idx] && m_dirty[v][idx]) begin
        t.we = 1; t.addr = {m_tag[v][idx], idx}; t.wdata = m_data[v][idx];
        exp_mem.push_back(t);
        bmem[t.addr] = t.wdata;
        m_wbs = sinc(m_wbs);
        r.mem = 1;
      end
      if (wr) begin
        r.data = wd;
      end else begin
        t.we = 0; t.addr = {tag, idx}; t.wdata = '0;
        exp_mem.push_back(t);
        r.data = bmem[t.addr];
        r.mem = 1;
      end
      m_valid[v][idx] = 1;
      m_dirty[v][idx] = wr;
      m_tag[v][idx]   = tag;
      m_data[v][idx]  = r.data;
      m_lru[idx]      = 1 - v;
    end
    exp_resp.push_back(r);
  endfunction

  // Compare process plus memory responder, both on the falling edge.
  initial begin
    rsp_t e;
    mtx_t t;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mem_ack = 0;
        busy = 0;
        continue;
      end
      check("req_ready", req_ready, !outstanding);
      if (mem_req) begin
        mem_cycles++;
        if (exp_mem.size() == 0) fail_now("mem_req_unexpected");
        else begin
          check("mem_we", mem_we, exp_mem[0].we);
          check("mem_addr", mem_addr, exp_mem[0].addr);
          if (exp_mem[0].we) check("mem_wdata", mem_wdata, exp_mem[0].wdata);
        end
      end
      if (resp_valid) begin
        if (exp_resp.size() == 0) fail_now("resp_unexpected");
        else begin
          e = exp_resp.pop_front();
          check("resp_hit", resp_hit, e.hit);
          check("resp_data", resp_data, e.data);
          check("mem_txns_done", exp_mem.size(), 0);
          if (e.mem) check("resp_after_ack", cyc - ack_cyc, 1);
          else       check("resp_latency", cyc - hs_cyc, 2);
        end
        last_hit  = resp_hit;
        last_data = resp_data;
        last_lat  = cyc - hs_cyc;
        resp_seen++;
      end
      if (!outstanding && !req_valid) begin
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
        check("wb_count", wb_count, m_wbs);
      end
      if (resp_valid) outstanding = 0;
      if (req_valid && req_ready) begin
        outstanding = 1;
        hs_cyc = cyc;
      end
      mem_ack = 0;
      if (mem_req) begin
        if (!busy) begin
          busy = 1;
          wait_left = (delay_cfg < 0) ? int'($urandom_range(0, 3)) : delay_cfg;
        end
        if (wait_left == 0) begin
          mem_ack = 1;
          mem_rdata = bmem[mem_addr];
          busy = 0;
          ack_cyc = cyc;
          t.we = mem_we; t.addr = mem_addr; t.wdata = mem_wdata;
          log_mem.push_back(t);
          if (exp_mem.size() != 0) void'(exp_mem.pop_front());
        end else begin
          wait_left--;
        end
      end else if (spurious_en && $urandom_range(0, 7) == 0) begin
        mem_ack = 1;
        mem_rdata = 3'($urandom);
      end
    end
  end

  task automatic start_req(input bit wr, input logic [1:0] idx,
                           input logic [2:0] tag, input logic [2:0] wd);
    int n = 0;
    @(posedge clk); #2;
    while (!req_ready && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    if (!req_ready) fail_now("ready_wait");
    log_mem.delete();
    mem_cycles = 0;
    req_wr = wr; req_index = idx; req_tag = tag; req_wdata = wd;
    req_valid = 1;
    predict(wr, idx, tag, wd);
    @(posedge clk); #2;
    req_valid = 0;
    req_wdata = 3'($urandom);
  endtask

  task automatic do_req(input bit wr, input logic [1:0] idx,
                        input logic [2:0] tag, input logic [2:0] wd);
    int base = resp_seen;
    int n = 0;
    start_req(wr, idx, tag, wd);
    while (resp_seen == base && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    if (resp_seen == base) fail_now("resp_wait");
  endtask

  initial begin
    int n;
    for (int a = 0; a < 32; a++) bmem[a] = 3'($urandom);
    bmem[5'b10101] = 3'b110;
    bmem[5'b11110] = 3'b001;
    model_clear();

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_hit", resp_hit, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_counts", {hit_count, miss_count, wb_count}, 0);
    #2 rst = 0;

    // Read miss then hit on index 1, tag 5
    do_req(0, 2'd1, 3'd5, 3'd0);
    check("t1_txns", log_mem.size(), 1);
    if (log_mem.size() == 1) begin
      check("t1_refill_we", log_mem[0].we, 0);
      check("t1_refill_addr", log_mem[0].addr, 5'b10101);
    end
    check("t1_hit", last_hit, 0);
    check("t1_data", last_data, 3'b110);
    do_req(0, 2'd1, 3'd5, 3'd0);
    check("t1b_hit", last_hit, 1);
    check("t1b_data", last_data, 3'b110);
    check("t1b_latency", last_lat, 2);
    check("t1_hit_count", hit_count, 1);
    check("t1_miss_count", miss_count, 1);

    // Write misses on index 2, then a dirty LRU eviction
    do_req(1, 2'd2, 3'd3, 3'b011);
    check("t2_wr3_txns", log_mem.size(), 0);
    do_req(1, 2'd2, 3'd4, 3'b101);
    check("t2_wr4_txns", log_mem.size(), 0);
    do_req(0, 2'd2, 3'd3, 3'd0);
    check("t2_rd3_hit", last_hit, 1);
    check("t2_rd3_data", last_data, 3'b011);
    do_req(1, 2'd2, 3'd6, 3'b111);
    check("t2_wr6_txns", log_mem.size(), 1);
    if (log_mem.size() == 1) begin
      check("t2_wb_we", log_mem[0].we, 1);
      check("t2_wb_addr", log_mem[0].addr, 5'b10010);
      check("t2_wb_wdata", log_mem[0].wdata, 3'b101);
    end
    check("t2_wb_count", wb_count, 1);

    // Read miss evicting dirty tag 3: write-back then refill, line ends clean
    do_req(0, 2'd2, 3'd7, 3'd0);
    check("t3_txns", log_mem.size(), 2);
    if (log_mem.size() == 2) begin
      check("t3_first_we", log_mem[0].we, 1);
      check("t3_first_addr", log_mem[0].addr, 5'b01110);
      check("t3_first_wdata", log_mem[0].wdata, 3'b011);
      check("t3_second_we", log_mem[1].we, 0);
      check("t3_second_addr", log_mem[1].addr, 5'b11110);
    end
    check("t3_data", last_data, 3'b001);
    do_req(0, 2'd2, 3'd7, 3'd0);
    do_req(0, 2'd2, 3'd6, 3'd0);
    do_req(0, 2'd2, 3'd1, 3'd0);
    check("t3_clean_evict_txns", log_mem.size(), 1);
    if (log_mem.size() == 1) check("t3_clean_evict_we", log_mem[0].we, 0);

    // Slow memory: 5 wait cycles before ack
    delay_cfg = 5;
    do_req(0, 2'd3, 3'd0, 3'd0);
    check("t4_mem_req_cycles", mem_cycles, 6);
    check("t4_hit", last_hit, 0);

    // Reset during REFILL
    delay_cfg = 10;
    start_req(0, 2'd0, 3'd2, 3'd0);
    n = 0;
    while (!(mem_req && !mem_we) && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (!(mem_req && !mem_we)) fail_now("t5_refill_wait");
    repeat (2) @(negedge clk);
    #2 rst = 1;
    #1;
    check("t5_mem_req_drop", mem_req, 0);
    check("t5_counts", {hit_count, miss_count, wb_count}, 0);
    model_clear();
    outstanding = 0;
    @(negedge clk);
    #2 rst = 0;
    delay_cfg = 0;
    do_req(0, 2'd0, 3'd2, 3'd0);
    check("t5_reread_hit", last_hit, 0);

    // Miss counter saturation
    for (int i = 0; i < 300; i++)
      do_req(0, 2'(i % 4), 3'((i / 4) % 8), 3'd0);
    check("t6_miss_sat", miss_count, 255);

    // Randomized traffic with random memory latency and stray acks
    delay_cfg = -1;
    spurious_en = 1;
    for (int i = 0; i < 150; i++) begin
      do_req(1'($urandom), 2'($urandom), 3'($urandom_range(0, 3)), 3'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    spurious_en = 0;
    repeat (3) @(negedge clk);
    check("final_resp_queue", exp_resp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Sequencing controller for the 2-way set-associative, 4-set write-back cache with 3-bit lines and 3-bit tags.
- Owns the tag, data, valid, dirty and LRU state.
- Accepts one read/write request at a time from the core side.
- On a miss it runs the victim write-back and line refill against a backing memory through a req/ack handshake.
- Sits between the core load/store port and main memory, and exports hit/miss statistics.

## Interface
- INDEX_W, 2, set index width (4 sets)
- TAG_W, 3, tag width
- DATA_W, 3, line/data width (one word per line)
- CNT_W, 8, statistics counter width
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  core request present
- req_ready  out  1  controller can accept (high only in IDLE)
- req_wr  in  1  1 = write, 0 = read
- req_index  in  INDEX_W  set index
- req_tag  in  TAG_W  tag
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  one-cycle response pulse
- resp_hit  out  1  request hit (valid with resp_valid)
- resp_data  out  DATA_W  read data (writes return written data)
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write-back, 0 = refill
- mem_addr  out  TAG_W+INDEX_W  {tag, index}
- mem_wdata  out  DATA_W  victim data
- mem_ack  in  1  memory completes transaction (one cycle)
- mem_rdata  in  DATA_W  refill data, valid with mem_ack
- hit_count, miss_count, wb_count  out  CNT_W  saturating statistics

## Operation
- States: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE: req_ready=1. A handshake (req_valid&req_ready) latches wr/index/tag/wdata and moves to LOOKUP.
- LOOKUP: compares the latched tag against both ways of the set; a hit requires valid and a tag match.
  - Hit: update the line. A write sets data=wdata and dirty=1; a read leaves data unchanged. Set LRU to the other way, increment hit_count, go to RESPOND.
  - Miss: increment miss_count and select the victim:
    - the first invalid way, way0 preferred;
    - otherwise the way named by the set's LRU bit.
  - If the victim is valid&dirty, go to WRITEBACK. Otherwise a read goes to REFILL and a write goes to RESPOND.
  - A write miss is a full-line write, so no refill is performed.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data.
  - On mem_ack: increment wb_count. A read goes to REFILL; a write goes to RESPOND.
- REFILL: mem_req=1, mem_we=0, mem_addr={req tag, index}.
  - On mem_ack: install mem_rdata into the victim way, go to RESPOND.
- RESPOND: install the line as valid with tag=req tag.
  - Read miss: dirty=0, data=mem_rdata.
  - Write miss: dirty=1, data=wdata.
  - Hit lines were updated in LOOKUP.
  - Set LRU to the non-accessed way. Pulse resp_valid with resp_hit and resp_data. Return to IDLE.
- Counters saturate at 2^CNT_W-1.
- mem_ack outside WRITEBACK/REFILL is ignored.

## Timing
- Reset (async):
  - state=IDLE.
  - All valid/dirty/LRU bits cleared; data/tag arrays are don't-care.
  - req_ready=1; resp_valid, resp_hit, resp_data, mem_req, mem_we, mem_addr, mem_wdata are all 0.
  - Counters are 0.
- Reset asserted mid-transaction aborts it: mem_req drops asynchronously and no array update occurs.
- All outputs are registered or decoded from the state register; there is no combinational path from req_valid or mem_ack to outputs.
- Hit latency: handshake at edge N, LOOKUP in cycle N+1, resp_valid high in cycle N+2, next request can be accepted at edge N+3.
- Clean miss: resp_valid one cycle after the mem_ack cycle.
- mem_req, mem_we, mem_addr and mem_wdata are held stable from assertion until the mem_ack cycle inclusive.
  - mem_req falls the cycle after mem_ack.
  - mem_ack may arrive in the first mem_req cycle (zero wait).
- Back-to-back requests to the same set observe the state written by the previous request.

## Structure
- Package cache_pkg holds:
  - the state enum;
  - INDEX_W, TAG_W and DATA_W constants;
  - the line struct {valid, dirty, tag, data}.
- Sub-module cache_tag_store is natural. It contains:
  - the 2x4 line array plus 4 LRU bits;
  - a combinational read port producing per-way hit and line contents;
  - one synchronous write port with a way select;
  - async clear of valid, dirty and LRU.
- cache_ctrl keeps the FSM, request latch, memory interface and counters.

## Test plan
- Reset, then read index 1, tag 5:
  - response: miss and REFILL mem_addr=5'b10101;
  - with mem_ack and mem_rdata=3'b110: resp_data=110, resp_hit=0;
  - repeating the read gives resp_hit=1, data 110, response 2 cycles after the handshake;
  - hit_count=1, miss_count=1.
- Write index 2 tags 3, then 4:
  - both are write misses with no memory traffic;
  - a read of tag 3 hits;
  - a write of tag 6 evicts tag 4 (LRU) via WRITEBACK with mem_addr={4,2} and mem_wdata = the tag-4 data;
  - wb_count=1.
- Read miss evicting a dirty line: WRITEBACK precedes REFILL; mem_we is 1 then 0; the final line is clean.
- Insert 5-cycle mem_ack delays: mem_req and mem_addr hold stable; req_ready stays 0 throughout.
- Assert reset during REFILL: mem_req=0 immediately; counters are 0; a subsequent read of the same address misses.
- Issue 300 misses: miss_count saturates at 255.
